riscv_test_monitor: RTL and testbench
=====================================

RISCV_TEST_MONITOR -- requirements
Module: riscv_test_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- XLEN, 64, writeback data width
- LOOP_COUNT, 16, consecutive same-PC commits that mean the core has halted
- TIMEOUT_CYCLES, 1000000, RUN-state cycle budget
- CNT_W, 32, counter width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Clock and reset come first.
- clk, in, 1, single clock, rising edge
- rst, in, 1, reset, synchronous, active-high
- valid, in, 1, instruction committed this cycle
- pc, in, XLEN, PC of the committed instruction
- we, in, 1, committed instruction writes the register file
- addr, in, 5, destination register index
- data, in, XLEN, writeback data
- r3, out, XLEN, last value written to x3 (gp)
- done, out, 1, test finished (PASS, FAIL or TIMEOUT)
- pass, out, 1, test passed
- fail, out, 1, test failed
- timeout, out, 1, cycle budget exhausted
- fail_testnum, out, XLEN, failing test number (r3 >> 1)
- retired, out, CNT_W, committed-instruction count
- cycles, out, CNT_W, cycles spent in RUN
REQ-003 All outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have the states IDLE, RUN, PASS, FAIL and TIMEOUT.
REQ-005 IDLE SHALL move to RUN on the first cycle with valid=1; that commit is processed as a RUN commit.
REQ-006 When valid&&we&&addr==3, r3 SHALL take data at the next edge (1-cycle latency) in IDLE and RUN; r3 SHALL be frozen in terminal states.
REQ-007 In RUN, cycles SHALL increment by 1 every cycle, and retired SHALL increment on each valid.
REQ-008 last_pc SHALL record pc on every valid.
REQ-009 same_cnt SHALL increment on valid with pc==last_pc and clear to 0 on valid with pc!=last_pc; it SHALL hold when valid=0.
REQ-010 Halt SHALL be detected on a valid commit with pc==last_pc while same_cnt==LOOP_COUNT-1, i.e. the LOOP_COUNT-th repeat.
REQ-011 At halt, the evaluated value SHALL be data if that same commit writes x3 (bypass), otherwise r3.
REQ-012 At halt, an evaluated value of 1 SHALL go to PASS; any other value SHALL go to FAIL with fail_testnum = value >> 1 (logical shift), so value 0 gives FAIL with testnum 0.
REQ-013 In RUN, the state SHALL go to TIMEOUT when cycles == TIMEOUT_CYCLES-1 at a clock edge with no halt; halt wins over timeout on the same edge.
REQ-014 Terminal states SHALL be sticky until rst.
REQ-015 In terminal states, retired and cycles SHALL hold and all inputs SHALL be ignored.
REQ-016 done SHALL be 1 in any terminal state.
REQ-017 Exactly one of pass, fail and timeout SHALL be 1 while done=1; all three SHALL be 0 otherwise.
REQ-018 Terminal flags SHALL assert on the edge that enters the state, one cycle after the halting commit.
REQ-019 Counters SHALL wrap modulo 2^CNT_W; a parameter check SHALL require TIMEOUT_CYCLES < 2^CNT_W.

Reset
REQ-020 On rst=1 at a rising edge, the block SHALL go to IDLE and clear r3, fail_testnum, retired, cycles, same_cnt, last_pc, done, pass, fail and timeout to 0.
REQ-021 rst SHALL take priority over every input in the same cycle, including a halting commit.
REQ-022 rst asserted mid-RUN SHALL abort the test; the next valid SHALL start a new RUN from zeroed counters.

Verification
REQ-023 Pass case: write x3=1, then 16 commits at pc=0x80000100 -> pass=1, done=1 one cycle after the 16th commit, fail=0.
REQ-024 Fail case: write x3=0x7 (test 3 failed), then 16 commits at the same pc -> fail=1, fail_testnum=3.
REQ-025 Bypass case: the 16th same-pc commit also writes x3=1 with r3 previously 0x5 -> PASS; r3 stays 0x5, frozen because the write lands in a terminal state.
REQ-026 Loop-reset case: 15 same-pc commits, one commit at pc+4, then 15 more at the original pc -> no halt; the 16th repeat halts.
REQ-027 Timeout case: TIMEOUT_CYCLES=100 with no halt -> timeout=1 and cycles=99.
REQ-028 Timeout tie case: halt and the timeout edge coincide -> PASS or FAIL, not TIMEOUT.
REQ-029 Reset mid-run: rst after 50 commits -> all outputs 0 and IDLE; a fresh pass sequence then passes with retired=16.

Source files
------------

// File: rtl/riscv_test_monitor.sv
// Watches the commit stream of a RISC-V core running a riscv-tests program and
// reports PASS/FAIL/TIMEOUT from gp (x3) once the core parks in its halt loop.
module riscv_test_monitor #(
   parameter int     XLEN           = 64,
   parameter int     LOOP_COUNT     = 16,
   parameter longint TIMEOUT_CYCLES = 1000000,
   parameter int     CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [XLEN-1:0]  pc,
   input  logic             we,
   input  logic [4:0]       addr,
   input  logic [XLEN-1:0]  data,
   output logic [XLEN-1:0]  r3,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [XLEN-1:0]  fail_testnum,
   output logic [CNT_W-1:0] retired,
   output logic [CNT_W-1:0] cycles
);

   localparam int               SCW       = $clog2(LOOP_COUNT + 1);
   localparam logic [SCW-1:0]   SAME_LAST = SCW'(LOOP_COUNT - 1);
   localparam logic [SCW-1:0]   SAME_ONE  = SCW'(1);
   localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [XLEN-1:0]  X_ONE     = XLEN'(1);
   localparam longint           CNT_SPAN  = (CNT_W >= 63) ? longint'(64'h7FFF_FFFF_FFFF_FFFF)
                                                          : (longint'(1) <<< CNT_W);

   // The timeout compare must be reachable by a counter that wraps at 2^CNT_W.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= CNT_SPAN || LOOP_COUNT < 1) begin : g_paramCheck
      $error("riscv_test_monitor: need 1 <= TIMEOUT_CYCLES < 2**CNT_W and LOOP_COUNT >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_PASS,
      S_FAIL,
      S_TIMEOUT
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [SCW-1:0]   r_sameCnt;
   logic [XLEN-1:0]  r_lastPc;

   logic             w_active;
   logic             w_wrX3;
   logic             w_halt;
   logic             w_cycLimit;
   logic             w_advance;
   logic [XLEN-1:0]  w_evalVal;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // The first commit seen in IDLE is treated exactly like a RUN commit.
   always_comb begin
      w_nextState = r_state;
      w_active    = (r_state == S_RUN) || ((r_state == S_IDLE) && valid);
      w_wrX3      = valid && we && (addr == 5'd3);
      w_halt      = w_active && valid && (pc == r_lastPc) && (r_sameCnt == SAME_LAST);
      w_cycLimit  = w_active && (cycles == CYC_LAST);
      w_evalVal   = w_wrX3 ? data : r3;
      w_advance   = w_active && !w_halt && !w_cycLimit;
      if (w_active) begin
         if (w_halt) begin
            w_nextState = (w_evalVal == X_ONE) ? S_PASS : S_FAIL;
         end else if (w_cycLimit) begin
            w_nextState = S_TIMEOUT;
         end else begin
            w_nextState = S_RUN;
         end
      end
   end

   // Counters, r3 and loop tracking freeze on the edge that enters a terminal state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r3           <= '0;
         fail_testnum <= '0;
         retired      <= '0;
         cycles       <= '0;
         r_sameCnt    <= '0;
         r_lastPc     <= '0;
         done         <= 1'b0;
         pass         <= 1'b0;
         fail         <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         pass    <= (w_nextState == S_PASS);
         fail    <= (w_nextState == S_FAIL);
         timeout <= (w_nextState == S_TIMEOUT);
         done    <= (w_nextState == S_PASS) || (w_nextState == S_FAIL) ||
                    (w_nextState == S_TIMEOUT);
         if (w_halt) begin
            fail_testnum <= w_evalVal >> 1;
         end
         if (w_advance) begin
            cycles <= cycles + CNT_ONE;
            if (valid) begin
               retired  <= retired + CNT_ONE;
               r_lastPc <= pc;
               if (w_wrX3) begin
                  r3 <= data;
               end
               if (pc == r_lastPc) begin
                  r_sameCnt <= r_sameCnt + SAME_ONE;
               end else begin
                  r_sameCnt <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: two instances (default budget and a 100-cycle
// budget) share one stimulus stream and are compared against a commit-level model.
module tb_riscv_test_monitor;

   localparam int          LOOP = 16;
   localparam logic [63:0] P    = 64'h8000_0100;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        valid = 1'b0;
   logic        we    = 1'b0;
   logic [4:0]  addr  = '0;
   logic [63:0] pc    = '0;
   logic [63:0] data  = '0;

   logic [63:0] r3W[2];
   logic [63:0] ftnW[2];
   logic        doneW[2];
   logic        passW[2];
   logic        failW[2];
   logic        toutW[2];
   logic [31:0] retW[2];
   logic [31:0] cycW[2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   riscv_test_monitor #(.XLEN(64), .LOOP_COUNT(LOOP), .TIMEOUT_CYCLES(1000000), .CNT_W(32)) dut0 (
      .clk(clk), .rst(rst), .valid(valid), .pc(pc), .we(we), .addr(addr), .data(data),
      .r3(r3W[0]), .done(doneW[0]), .pass(passW[0]), .fail(failW[0]), .timeout(toutW[0]),
      .fail_testnum(ftnW[0]), .retired(retW[0]), .cycles(cycW[0])
   );

   riscv_test_monitor #(.XLEN(64), .LOOP_COUNT(LOOP), .TIMEOUT_CYCLES(100), .CNT_W(32)) dut1 (
      .clk(clk), .rst(rst), .valid(valid), .pc(pc), .we(we), .addr(addr), .data(data),
      .r3(r3W[1]), .done(doneW[1]), .pass(passW[1]), .fail(failW[1]), .timeout(toutW[1]),
      .fail_testnum(ftnW[1]), .retired(retW[1]), .cycles(cycW[1])
   );

   // Reference model: runLen is the number of consecutive commits at lastPc,
   // counting the reset value of lastPc as one virtual commit.
   typedef struct {
      logic [63:0] r3;
      logic [63:0] ftn;
      logic [63:0] lastPc;
      logic [31:0] ret;
      logic [31:0] cyc;
      int          runLen;
      bit          started;
      bit          done;
      bit          pass;
      bit          fail;
      bit          tout;
   } model_t;

   model_t m[2];
   longint toLim[2] = '{1000000, 100};

   task automatic modelStep();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m[k] = '{default: 0};
            m[k].runLen = 1;
         end else if (!m[k].done && (m[k].started || valid)) begin
            bit          hit;
            logic [63:0] v;
            m[k].started = 1;
            hit = valid && (pc == m[k].lastPc) && (m[k].runLen == LOOP);
            if (hit) begin
               v = (we && addr == 5'd3) ? data : m[k].r3;
               m[k].done = 1;
               m[k].pass = (v == 64'd1);
               m[k].fail = (v != 64'd1);
               m[k].ftn  = v >> 1;
            end else if (longint'(m[k].cyc) == toLim[k] - 1) begin
               m[k].done = 1;
               m[k].tout = 1;
            end else begin
               m[k].cyc = m[k].cyc + 1;
               if (valid) begin
                  m[k].ret = m[k].ret + 1;
                  if (we && addr == 5'd3) m[k].r3 = data;
                  m[k].runLen = (pc == m[k].lastPc) ? m[k].runLen + 1 : 1;
                  m[k].lastPc = pc;
               end
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [63:0] p, input logic w,
                                input logic [4:0] a, input logic [63:0] d);
      valid = v;
      pc    = p;
      we    = w;
      addr  = a;
      data  = d;
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, '0, '0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(1'b1, P, 1'b1, 5'd3, 64'd1);
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({doneW[k], passW[k], failW[k], toutW[k]} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags dut%0d: got %b expected 0000", k,
                     {doneW[k], passW[k], failW[k], toutW[k]});
         end
         checks++;
         if ({r3W[k], ftnW[k], retW[k], cycW[k]} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values dut%0d: got r3=%0h ftn=%0h ret=%0d cyc=%0d expected all 0",
                     k, r3W[k], ftnW[k], retW[k], cycW[k]);
         end
      end
   endtask

   // Writes x3 at the loop PC, then LOOP more commits there; the last one halts.
   task automatic runLoop(input logic [63:0] x3Val, input bit lastWritesX3, input logic [63:0] lastVal);
      applyStimulus(1'b1, P, 1'b1, 5'd3, x3Val);
      for (int i = 0; i < LOOP - 1; i++) applyStimulus(1'b1, P, 1'b0, 5'd0, {$urandom, $urandom});
      checks++;
      if (doneW[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL early_done: got %b expected 0", doneW[0]);
      end
      applyStimulus(1'b1, P, lastWritesX3, lastWritesX3 ? 5'd3 : 5'd0, lastVal);
   endtask

   task automatic test_pass();
      doReset();
      runLoop(64'd1, 1'b0, 64'd0);
      checks++;
      if ({doneW[0], passW[0], failW[0], toutW[0]} !== 4'b1100) begin
         errors++;
         $display("[TB] FAIL pass_flags: got %b expected 1100", {doneW[0], passW[0], failW[0], toutW[0]});
      end
      checks++;
      if (retW[0] !== m[0].ret) begin
         errors++;
         $display("[TB] FAIL pass_retired: got %0d expected %0d", retW[0], m[0].ret);
      end
   endtask

   task automatic test_fail();
      doReset();
      runLoop(64'h7, 1'b0, 64'd0);
      checks++;
      if ({doneW[0], passW[0], failW[0], toutW[0]} !== 4'b1010) begin
         errors++;
         $display("[TB] FAIL fail_flags: got %b expected 1010", {doneW[0], passW[0], failW[0], toutW[0]});
      end
      checks++;
      if (ftnW[0] !== 64'd3) begin
         errors++;
         $display("[TB] FAIL fail_testnum: got %0h expected 3", ftnW[0]);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] retHeld;
      doReset();
      runLoop(64'h5, 1'b1, 64'd1);
      checks++;
      if (passW[0] !== 1'b1 || failW[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bypass_pass: got pass=%b fail=%b expected pass=1 fail=0", passW[0], failW[0]);
      end
      checks++;
      if (r3W[0] !== 64'h5) begin
         errors++;
         $display("[TB] FAIL bypass_r3: got %0h expected 5", r3W[0]);
      end
      retHeld = m[0].ret;
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, P + 64'(4 * i), 1'b1, 5'd3, 64'h77);
      checks++;
      if (r3W[0] !== 64'h5 || retW[0] !== retHeld || doneW[0] !== 1'b1 || passW[0] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sticky_terminal: got r3=%0h ret=%0d done=%b pass=%b expected r3=5 ret=%0d done=1 pass=1",
                  r3W[0], retW[0], doneW[0], passW[0], retHeld);
      end
   endtask

   task automatic test_loop_reset();
      int extra;
      doReset();
      applyStimulus(1'b1, P, 1'b1, 5'd3, 64'd1);
      for (int i = 0; i < 14; i++) applyStimulus(1'b1, P, 1'b0, 5'd0, 64'd0);
      applyStimulus(1'b1, P + 64'd4, 1'b0, 5'd0, 64'd0);
      for (int i = 0; i < 15; i++) applyStimulus(1'b1, P, 1'b0, 5'd0, 64'd0);
      checks++;
      if (doneW[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL loop_reset_nohalt: got done=%b expected 0", doneW[0]);
      end
      extra = 0;
      while (!m[0].done && extra < 4) begin
         applyStimulus(1'b1, P, 1'b0, 5'd0, 64'd0);
         extra++;
      end
      checks++;
      if (extra !== 2 || doneW[0] !== 1'b1 || passW[0] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL loop_reset_halt: got extra=%0d done=%b pass=%b expected extra=2 done=1 pass=1",
                  extra, doneW[0], passW[0]);
      end
   endtask

   task automatic test_timeout();
      doReset();
      for (int i = 0; i < 110; i++) begin
         applyStimulus((i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 64'h1000 + 64'(4 * i), 1'b0, 5'd0, 64'd0);
         checks++;
         if (toutW[1] !== m[1].tout) begin
            errors++;
            $display("[TB] FAIL timeout_step%0d: got %b expected %b", i, toutW[1], m[1].tout);
         end
      end
      checks++;
      if ({doneW[1], passW[1], failW[1], toutW[1]} !== 4'b1001 || cycW[1] !== 32'd99) begin
         errors++;
         $display("[TB] FAIL timeout_final: got flags=%b cycles=%0d expected flags=1001 cycles=99",
                  {doneW[1], passW[1], failW[1], toutW[1]}, cycW[1]);
      end
      checks++;
      if (retW[1] !== m[1].ret || toutW[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL timeout_retired: got ret=%0d big_tout=%b expected ret=%0d big_tout=0",
                  retW[1], toutW[0], m[1].ret);
      end
   endtask

   task automatic test_timeout_tie();
      doReset();
      for (int i = 0; i < 83; i++) applyStimulus(1'b1, 64'h2000 + 64'(4 * i), 1'b0, 5'd0, 64'd0);
      applyStimulus(1'b1, P, 1'b1, 5'd3, 64'd1);
      for (int i = 0; i < LOOP; i++) applyStimulus(1'b1, P, 1'b0, 5'd0, 64'd0);
      checks++;
      if ({doneW[1], passW[1], failW[1], toutW[1]} !== 4'b1100 || cycW[1] !== 32'd99) begin
         errors++;
         $display("[TB] FAIL timeout_tie: got flags=%b cycles=%0d expected flags=1100 cycles=99",
                  {doneW[1], passW[1], failW[1], toutW[1]}, cycW[1]);
      end
   endtask

   task automatic test_reset_mid_run();
      doReset();
      for (int i = 0; i < 34; i++) applyStimulus(1'b1, 64'h3000 + 64'(4 * i), 1'b0, 5'd0, 64'd0);
      applyStimulus(1'b1, P, 1'b1, 5'd3, 64'd1);
      for (int i = 0; i < 15; i++) applyStimulus(1'b1, P, 1'b0, 5'd0, 64'd0);
      rst = 1'b1;
      applyStimulus(1'b1, P, 1'b0, 5'd0, 64'd0);
      rst = 1'b0;
      checks++;
      if ({doneW[0], passW[0], failW[0], toutW[0]} !== 4'b0000 ||
          {r3W[0], ftnW[0], retW[0], cycW[0]} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mid_run: got flags=%b r3=%0h ret=%0d cyc=%0d expected all 0",
                  {doneW[0], passW[0], failW[0], toutW[0]}, r3W[0], retW[0], cycW[0]);
      end
      applyStimulus(1'b0, P, 1'b0, 5'd0, 64'd0);
      checks++;
      if (cycW[0] !== 32'd0 || doneW[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: got cyc=%0d done=%b expected cyc=0 done=0", cycW[0], doneW[0]);
      end
      runLoop(64'd1, 1'b0, 64'd0);
      checks++;
      if (passW[0] !== 1'b1 || retW[0] !== 32'd16) begin
         errors++;
         $display("[TB] FAIL rerun_pass: got pass=%b ret=%0d expected pass=1 ret=16", passW[0], retW[0]);
      end
   endtask

   task automatic test_random();
      logic [63:0] curPc;
      logic [63:0] d;
      for (int round = 0; round < 4; round++) begin
         doReset();
         curPc = P;
         for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 9) == 0) curPc = P + 64'(4 * $urandom_range(0, 3));
            case ($urandom_range(0, 2))
               0:       d = 64'd1;
               1:       d = 64'($urandom_range(0, 15));
               default: d = {$urandom, $urandom};
            endcase
            rst = ($urandom_range(0, 127) == 0);
            applyStimulus(($urandom_range(0, 3) != 0), curPc, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 1) == 1) ? 5'd3 : 5'($urandom_range(0, 31)), d);
            rst = 1'b0;
            for (int k = 0; k < 2; k++) begin
               checks++;
               if ({doneW[k], passW[k], failW[k], toutW[k]} !== {m[k].done, m[k].pass, m[k].fail, m[k].tout}) begin
                  errors++;
                  $display("[TB] FAIL rand_flags dut%0d r%0d c%0d: got %b expected %b", k, round, c,
                           {doneW[k], passW[k], failW[k], toutW[k]}, {m[k].done, m[k].pass, m[k].fail, m[k].tout});
               end
               checks++;
               if (r3W[k] !== m[k].r3 || ftnW[k] !== m[k].ftn || retW[k] !== m[k].ret || cycW[k] !== m[k].cyc) begin
                  errors++;
                  $display("[TB] FAIL rand_values dut%0d r%0d c%0d: got r3=%0h ftn=%0h ret=%0d cyc=%0d expected r3=%0h ftn=%0h ret=%0d cyc=%0d",
                           k, round, c, r3W[k], ftnW[k], retW[k], cycW[k], m[k].r3, m[k].ftn, m[k].ret, m[k].cyc);
               end
            end
         end
      end
   endtask

   initial begin
      m[0] = '{default: 0};
      m[1] = '{default: 0};
      m[0].runLen = 1;
      m[1].runLen = 1;
      @(negedge clk);
      test_reset();
      test_pass();
      test_fail();
      test_bypass();
      test_loop_reset();
      test_timeout();
      test_timeout_tie();
      test_reset_mid_run();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
